// File: rtl/mac_rx_frame_parse_pkg.sv
// Shared types and Ethernet framing constants for the rx frame parser and its FCS stripper.
package mac_rx_frame_parse_pkg;

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    PAY  = 2'd1,
    DROP = 2'd2
  } rx_parse_state_t;

  localparam logic [3:0]  ETH_HDR_LEN = 4'd14;
  localparam logic [2:0]  ETH_FCS_LEN = 3'd4;
  localparam logic [47:0] MAC_BCAST   = 48'hFFFF_FFFF_FFFF;

endpackage

// File: rtl/mac_rx_frame_parse_if.sv
// Frame byte stream in from CRC-verify plus AXI-Stream payload out to the L3 dispatcher.
// slave = the parser; master = the side feeding frame bytes and consuming payload.
interface mac_rx_frame_parse_if;
  logic [7:0] mac_rdata_in;
  logic       mac_rvalid_in;
  logic       mac_rready_out;
  logic       mac_rlast_in;
  logic [7:0] pay_tdata_out;
  logic       pay_tvalid_out;
  logic       pay_tready_in;
  logic       pay_tlast_out;
  logic       pay_terr_out;

  modport master (
    output mac_rdata_in, mac_rvalid_in, mac_rlast_in, pay_tready_in,
    input  mac_rready_out, pay_tdata_out, pay_tvalid_out, pay_tlast_out, pay_terr_out
  );

  modport slave (
    input  mac_rdata_in, mac_rvalid_in, mac_rlast_in, pay_tready_in,
    output mac_rready_out, pay_tdata_out, pay_tvalid_out, pay_tlast_out, pay_terr_out
  );
endinterface

// File: rtl/mac_rx_frame_parse_fcs_strip.sv
// 4-byte delay line that withholds the FCS, feeding a one-entry output register.
// A byte leaves only once four newer bytes are behind it, so the trailing FCS is never emitted.
module mac_rx_frame_parse_fcs_strip
  import mac_rx_frame_parse_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] i_data,
  input  logic       i_valid,
  input  logic       i_last,
  input  logic       i_err,
  input  logic       i_ready,
  output logic       o_ready,
  output logic       o_full,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_last,
  output logic       o_err
);

  logic [3:0][7:0] r_buf;
  logic [2:0]      r_fill;
  logic            w_load;

  assign o_full  = (r_fill == ETH_FCS_LEN);
  assign w_load  = i_valid && o_full;
  assign o_ready = !o_valid || i_ready;

  // r_buf[3] is the oldest byte once the line is full
  always_ff @(posedge clk) begin
    if (i_valid) r_buf <= {r_buf[2:0], i_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fill  <= 3'd0;
      o_data  <= 8'd0;
      o_valid <= 1'b0;
      o_last  <= 1'b0;
      o_err   <= 1'b0;
    end else begin
      if (i_valid) begin
        if (i_last)       r_fill <= 3'd0;
        else if (!o_full) r_fill <= r_fill + 3'd1;
      end
      if (w_load) begin
        o_valid <= 1'b1;
        o_data  <= r_buf[3];
        o_last  <= i_last;
        o_err   <= i_last && i_err;
      end else if (i_ready) begin
        o_valid <= 1'b0;
        o_last  <= 1'b0;
        o_err   <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/mac_rx_frame_parse.sv
// Ethernet rx header parser: captures dst/src/type, filters on dst MAC, strips the FCS
// and forwards the payload as AXI-Stream.
module mac_rx_frame_parse
  import mac_rx_frame_parse_pkg::*;
#(
  parameter bit          PROMISC       = 1'b0,
  parameter int unsigned MAX_FRAME_LEN = 1518
) (
  input  logic                 logic_clk,
  input  logic                 logic_rst_n,
  input  logic [47:0]          local_mac_in,
  mac_rx_frame_parse_if.slave  bus,
  output logic [47:0]          hdr_dst_mac_out,
  output logic [47:0]          hdr_src_mac_out,
  output logic [15:0]          hdr_type_out,
  output logic                 hdr_valid_out,
  output logic                 frame_drop_out
);

  localparam logic [1:0] S_HDR  = HDR;
  localparam logic [1:0] S_PAY  = PAY;
  localparam logic [1:0] S_DROP = DROP;

  function automatic logic [10:0] len_sat_inc(input logic [10:0] len);
    return (len == 11'h7FF) ? len : len + 11'd1;
  endfunction

  logic [1:0]  r_state;
  logic [3:0]  r_hdr_cnt;
  logic [10:0] r_frame_len;
  logic        r_run;
  logic [47:0] r_sh_dst;
  logic [47:0] r_sh_src;
  logic [47:0] r_local_mac;
  logic [7:0]  r_sh_type_hi;

  logic        w_acc;
  logic        w_hdr_acc;
  logic        w_hdr_end;
  logic        w_match;
  logic        w_pay_acc;
  logic        w_strip_ready;
  logic        w_strip_full;
  logic        w_len_err;
  logic        w_drop;
  logic [10:0] w_len_next;

  // r_run keeps ready low while reset is held and for the first cycle after release
  assign bus.mac_rready_out = r_run && ((r_state == S_DROP) || w_strip_ready);
  assign w_acc      = bus.mac_rvalid_in && bus.mac_rready_out;
  assign w_hdr_acc  = w_acc && (r_state == S_HDR);
  assign w_pay_acc  = w_acc && (r_state == S_PAY);
  assign w_hdr_end  = w_hdr_acc && (r_hdr_cnt == ETH_HDR_LEN - 4'd1) && !bus.mac_rlast_in;
  assign w_match    = PROMISC || (r_sh_dst == r_local_mac) || (r_sh_dst == MAC_BCAST);
  assign w_len_next = len_sat_inc(r_frame_len);
  assign w_len_err  = {21'd0, w_len_next} > MAX_FRAME_LEN;
  // zero-payload frames end in PAY with the FCS line never filled
  assign w_drop     = w_acc && bus.mac_rlast_in && ((r_state != S_PAY) || !w_strip_full);

  always_ff @(posedge logic_clk) begin
    if (w_hdr_acc) begin
      if (r_hdr_cnt == 4'd0) r_local_mac <= local_mac_in;
      if (r_hdr_cnt < 4'd6)       r_sh_dst     <= {r_sh_dst[39:0], bus.mac_rdata_in};
      else if (r_hdr_cnt < 4'd12) r_sh_src     <= {r_sh_src[39:0], bus.mac_rdata_in};
      else                        r_sh_type_hi <= bus.mac_rdata_in;
    end
  end

  always_ff @(posedge logic_clk or negedge logic_rst_n) begin
    if (!logic_rst_n) begin
      r_state         <= S_HDR;
      r_hdr_cnt       <= 4'd0;
      r_frame_len     <= 11'd0;
      r_run           <= 1'b0;
      hdr_dst_mac_out <= 48'd0;
      hdr_src_mac_out <= 48'd0;
      hdr_type_out    <= 16'd0;
      hdr_valid_out   <= 1'b0;
      frame_drop_out  <= 1'b0;
    end else begin
      r_run          <= 1'b1;
      hdr_valid_out  <= w_hdr_end && w_match;
      frame_drop_out <= w_drop;
      if (w_hdr_end && w_match) begin
        hdr_dst_mac_out <= r_sh_dst;
        hdr_src_mac_out <= r_sh_src;
        hdr_type_out    <= {r_sh_type_hi, bus.mac_rdata_in};
      end
      if (w_acc) begin
        r_frame_len <= bus.mac_rlast_in ? 11'd0 : w_len_next;
        case (r_state)
          S_HDR: begin
            if (bus.mac_rlast_in) begin
              r_hdr_cnt <= 4'd0;
            end else if (r_hdr_cnt == ETH_HDR_LEN - 4'd1) begin
              r_hdr_cnt <= 4'd0;
              r_state   <= w_match ? S_PAY : S_DROP;
            end else begin
              r_hdr_cnt <= r_hdr_cnt + 4'd1;
            end
          end
          S_PAY, S_DROP: if (bus.mac_rlast_in) r_state <= S_HDR;
          default:       r_state <= S_HDR;
        endcase
      end
    end
  end

  mac_rx_frame_parse_fcs_strip u_fcs_strip (
    .clk     (logic_clk),
    .rst_n   (logic_rst_n),
    .i_data  (bus.mac_rdata_in),
    .i_valid (w_pay_acc),
    .i_last  (bus.mac_rlast_in),
    .i_err   (w_len_err),
    .i_ready (bus.pay_tready_in),
    .o_ready (w_strip_ready),
    .o_full  (w_strip_full),
    .o_data  (bus.pay_tdata_out),
    .o_valid (bus.pay_tvalid_out),
    .o_last  (bus.pay_tlast_out),
    .o_err   (bus.pay_terr_out)
  );

endmodule

// File: tb/tb_mac_rx_frame_parse.sv
// Scoreboard bench for mac_rx_frame_parse: frames built here, expected payload queued as each
// frame is driven and popped as the DUT hands out payload beats.
module tb_mac_rx_frame_parse;

  localparam logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] OTHER_MAC = 48'h02_00_00_00_00_09;
  localparam logic [47:0] BCAST     = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SRC_BASE  = 48'h00_1B_21_AA_BB_00;
  localparam int          MAX_LEN   = 1518;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mac_rx_frame_parse_if bus ();
  logic [47:0] hdr_dst;
  logic [47:0] hdr_src;
  logic [15:0] hdr_type;
  logic        hdr_valid;
  logic        frame_drop;

  mac_rx_frame_parse #(.PROMISC(1'b0), .MAX_FRAME_LEN(MAX_LEN)) dut (
    .logic_clk       (clk),
    .logic_rst_n     (rst_n),
    .local_mac_in    (LOCAL_MAC),
    .bus             (bus),
    .hdr_dst_mac_out (hdr_dst),
    .hdr_src_mac_out (hdr_src),
    .hdr_type_out    (hdr_type),
    .hdr_valid_out   (hdr_valid),
    .frame_drop_out  (frame_drop)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [9:0]  exp_q[$];
  int          n_hdr_seen   = 0;
  int          n_drop_seen  = 0;
  int          exp_hdr_tot  = 0;
  int          exp_drop_tot = 0;
  logic [47:0] exp_dst  = 48'd0;
  logic [47:0] exp_src  = 48'd0;
  logic [15:0] exp_type = 16'd0;
  bit          rnd_ready = 1'b0;
  bit          done      = 1'b0;
  bit          prev_stall = 1'b0;
  logic [7:0]  prev_data  = 8'd0;
  logic [9:0]  mon_e;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic finish_tb();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  endtask

  always @(posedge clk) begin
    #1;
    bus.pay_tready_in = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (hdr_valid)  n_hdr_seen++;
      if (frame_drop) n_drop_seen++;
      if (prev_stall) begin
        check_eq("hold_valid", 64'(bus.pay_tvalid_out), 64'd1);
        check_eq("hold_data", 64'(bus.pay_tdata_out), 64'(prev_data));
      end
      if (bus.pay_tvalid_out && bus.pay_tready_in) begin
        if (exp_q.size() == 0) begin
          check_eq("beat_expected", 64'(exp_q.size()), 64'd1);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("pay_data", 64'(bus.pay_tdata_out), 64'(mon_e[7:0]));
          check_eq("pay_last", 64'(bus.pay_tlast_out), 64'(mon_e[8]));
          check_eq("pay_err",  64'(bus.pay_terr_out),  64'(mon_e[9]));
        end
      end
      prev_stall = bus.pay_tvalid_out && !bus.pay_tready_in;
      prev_data  = bus.pay_tdata_out;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_tvalid"}, 64'(bus.pay_tvalid_out), 64'd0);
    check_eq({tag, "_tlast"},  64'(bus.pay_tlast_out),  64'd0);
    check_eq({tag, "_terr"},   64'(bus.pay_terr_out),   64'd0);
    check_eq({tag, "_tdata"},  64'(bus.pay_tdata_out),  64'd0);
    check_eq({tag, "_rready"}, 64'(bus.mac_rready_out), 64'd0);
    check_eq({tag, "_hvalid"}, 64'(hdr_valid),          64'd0);
    check_eq({tag, "_drop"},   64'(frame_drop),         64'd0);
    check_eq({tag, "_hdst"},   64'(hdr_dst),            64'd0);
  endtask

  task automatic send_frame(input logic [47:0] dst, input int total, input logic [15:0] typ,
                            input int rst_at);
    logic [7:0]  fr[$];
    logic [47:0] src;
    bit          match, e_hdr, e_drop, acc;
    logic        e_last, e_err;
    int          stalls, waitc, sat_len;
    src = SRC_BASE | 48'($urandom_range(0, 255));
    for (int i = 0; i < 6; i++) fr.push_back(dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fr.push_back(src[47-8*i -: 8]);
    fr.push_back(typ[15:8]);
    fr.push_back(typ[7:0]);
    while (fr.size() < total) fr.push_back(8'($urandom_range(0, 255)));
    while (fr.size() > total) void'(fr.pop_back());

    match   = (dst == LOCAL_MAC) || (dst == BCAST);
    e_hdr   = match && (total > 14);
    e_drop  = (!e_hdr || total <= 18) && (rst_at < 0);
    sat_len = (total > 2047) ? 2047 : total;
    if (e_hdr) begin
      exp_hdr_tot++;
      exp_dst  = dst;
      exp_src  = src;
      exp_type = typ;
      for (int i = 14; i < total - 4; i++) begin
        e_last = (i == total - 5);
        e_err  = e_last && (sat_len > MAX_LEN);
        exp_q.push_back({e_err, e_last, fr[i]});
      end
    end
    if (e_drop) exp_drop_tot++;

    stalls = 0;
    for (int i = 0; i < total; i++) begin
      if (i == rst_at) begin
        bus.mac_rvalid_in = 1'b0;
        bus.mac_rlast_in  = 1'b0;
        check_eq("pre_rst_tvalid", 64'(bus.pay_tvalid_out), 64'd1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        return;
      end
      if (rnd_ready && $urandom_range(0, 3) == 0) begin
        bus.mac_rvalid_in = 1'b0;
        @(posedge clk);
        #1;
      end
      bus.mac_rdata_in  = fr[i];
      bus.mac_rlast_in  = (i == total - 1);
      bus.mac_rvalid_in = 1'b1;
      waitc = 0;
      forever begin
        @(negedge clk);
        acc = bus.mac_rready_out;
        @(posedge clk);
        #1;
        if (acc) break;
        stalls++;
        waitc++;
        if (waitc > 500) begin
          check_eq("rx_accept_timeout", 64'(bus.mac_rready_out), 64'd1);
          finish_tb();
          return;
        end
      end
    end
    bus.mac_rvalid_in = 1'b0;
    bus.mac_rlast_in  = 1'b0;
    if (!match && !rnd_ready) check_eq("drop_ready_held", 64'(stalls), 64'd0);
  endtask

  task automatic settle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    check_eq("drain_empty", 64'(exp_q.size()), 64'd0);
    check_eq("hdr_count",  64'(n_hdr_seen),  64'(exp_hdr_tot));
    check_eq("drop_count", 64'(n_drop_seen), 64'(exp_drop_tot));
    if (exp_hdr_tot > 0) begin
      check_eq("hdr_dst",  64'(hdr_dst),  64'(exp_dst));
      check_eq("hdr_src",  64'(hdr_src),  64'(exp_src));
      check_eq("hdr_type", 64'(hdr_type), 64'(exp_type));
    end
  endtask

  initial begin
    #1_000_000;
    check_eq("watchdog_done", 64'(done), 64'd1);
    finish_tb();
  end

  initial begin
    bus.mac_rvalid_in = 1'b0;
    bus.mac_rlast_in  = 1'b0;
    bus.mac_rdata_in  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    send_frame(LOCAL_MAC, 64, 16'h0800, -1);
    settle();

    send_frame(BCAST, 60, 16'h0806, -1);
    settle();
    send_frame(OTHER_MAC, 64, 16'h0800, -1);
    settle();

    send_frame(LOCAL_MAC, 10, 16'h0800, -1);
    settle();
    send_frame(LOCAL_MAC, 14, 16'h0800, -1);
    settle();
    send_frame(LOCAL_MAC, 18, 16'h88B5, -1);
    settle();
    send_frame(LOCAL_MAC, 19, 16'h0800, -1);
    settle();

    rnd_ready = 1'b1;
    send_frame(LOCAL_MAC, 100, 16'h0800, -1);
    settle();
    rnd_ready = 1'b0;

    send_frame(LOCAL_MAC, 64, 16'h0800, -1);
    send_frame(BCAST, 70, 16'h86DD, -1);
    settle();
    send_frame(LOCAL_MAC, 1518, 16'h0800, -1);
    send_frame(LOCAL_MAC, 1519, 16'h0800, -1);
    settle();
    send_frame(LOCAL_MAC, 1600, 16'h0800, -1);
    settle();

    send_frame(LOCAL_MAC, 100, 16'h0800, 34);
    send_frame(LOCAL_MAC, 64, 16'h0801, -1);
    settle();

    done = 1'b1;
    finish_tb();
  end

endmodule
